// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/datapath bundle for the multicycle RV32I controller.
//   op, zero, mem_ready        : datapath/memory -> controller
//   mem_req .. instret         : controller -> datapath/memory
// Modports: master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  ImmSrc;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for lw/sw/R-type/I-type/beq/jal on a
// shared-memory single-ALU datapath, with a variable-latency memory handshake
// and a retired-instruction counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (master) : op/zero/mem_ready in; datapath enables, mux selects,
//                  illegal and instret out
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes in
// HALT with illegal=1; otherwise they are dropped back to FETCH.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               reset_n,
  multicycle_ctrl_if.master  bus
);
  localparam int unsigned StateW = 4;
  localparam int unsigned CntW   = 32;

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [StateW-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CntW-1:0]   r_instret;

  logic       w_mem_req, w_pc_update, w_branch, w_adr_src, w_mem_write;
  logic       w_ir_write, w_reg_write, w_retire;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op, w_imm_src;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OpLw, OpSw: w_next = S_MEMADR;
          OpR:        w_next = S_EXECR;
          OpI:        w_next = S_EXECI;
          OpBeq:      w_next = S_BEQ;
          OpJal:      w_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:    w_next = S_HALT;
`else
          default:    w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = (bus.op == OpLw) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // Output decode; only FETCH looks at mem_ready
  always_comb begin
    w_mem_req    = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = bus.mem_ready;
        w_pc_update  = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format straight from the opcode
  always_comb begin
    case (bus.op)
      OpSw:    w_imm_src = 2'b01;
      OpBeq:   w_imm_src = 2'b10;
      OpJal:   w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  // JAL retires via ALUWB, so it is counted exactly once
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BEQ)   ||
                    ((r_state == S_MEMWRITE) && bus.mem_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CntW'(1);
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.PCWrite   = w_pc_update | (w_branch & bus.zero);
  assign bus.AdrSrc    = w_adr_src;
  assign bus.MemWrite  = w_mem_write;
  assign bus.IRWrite   = w_ir_write;
  assign bus.RegWrite  = w_reg_write;
  assign bus.ResultSrc = w_result_src;
  assign bus.ALUSrcA   = w_alu_src_a;
  assign bus.ALUSrcB   = w_alu_src_b;
  assign bus.ALUOp     = w_alu_op;
  assign bus.ImmSrc    = w_imm_src;
  assign bus.instret   = r_instret;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal   = (r_state == S_HALT);
`else
  assign bus.illegal   = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Each cycle the
// expected control vector (derived from the intended state walk of the
// instruction) is queued, then popped and compared to the DUT outputs.
module tb_multicycle_ctrl;
  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_HALT
  } tst_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0001111;

  logic clk;
  logic reset_n;
  multicycle_ctrl_if bus();

  multicycle_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected control outputs for a state, written out from the state table
  function automatic logic [16:0] exp_ctrl(input tst_t st, input logic [6:0] op,
                                           input logic z, input logic rdy);
    logic mreq, pcu, br, adr, mw, irw, rw;
    logic [1:0] rs, asa, asb, aop, imm;
    mreq = 0; pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; asa = 0; asb = 0; aop = 0;
    case (st)
      T_FETCH:    begin mreq = 1; asb = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
      T_DECODE:   begin asa = 2'b01; asb = 2'b01; end
      T_MEMADR:   begin asa = 2'b10; asb = 2'b01; end
      T_MEMREAD:  begin mreq = 1; adr = 1; end
      T_MEMWB:    begin rs = 2'b01; rw = 1; end
      T_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
      T_EXECR:    begin asa = 2'b10; aop = 2'b10; end
      T_EXECI:    begin asa = 2'b10; asb = 2'b01; aop = 2'b10; end
      T_ALUWB:    rw = 1;
      T_BEQ:      begin asa = 2'b10; aop = 2'b01; br = 1; end
      T_JAL:      begin asa = 2'b01; asb = 2'b10; pcu = 1; end
      default: ;
    endcase
    case (op)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
    return {mreq, pcu | (br & z), adr, mw, irw, rw, rs, asa, asb, aop, imm,
            logic'(st == T_HALT)};
  endfunction

  function automatic logic [63:0] observed();
    return {15'd0, bus.instret, bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite,
            bus.IRWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.ImmSrc, bus.illegal};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle: drive inputs at the negedge, queue expectation, compare, advance
  task automatic cyc(input tst_t st, input logic rdy, input logic z);
    logic [63:0] e;
    bus.mem_ready = rdy;
    bus.zero      = z;
    sb_q.push_back({15'd0, exp_instret, exp_ctrl(st, bus.op, z, rdy)});
    #1;
    e = sb_q.pop_front();
    check(st.name(), observed(), e);
    if (st == T_MEMWB || st == T_ALUWB || st == T_BEQ || (st == T_MEMWRITE && rdy))
      exp_instret = exp_instret + 32'd1;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    bus.op = op;
    repeat (fw) cyc(T_FETCH, 1'b0, rbit());
    cyc(T_FETCH, 1'b1, rbit());
    cyc(T_DECODE, rbit(), rbit());
    case (op)
      OP_LW: begin
        cyc(T_MEMADR, rbit(), rbit());
        repeat (mw) cyc(T_MEMREAD, 1'b0, rbit());
        cyc(T_MEMREAD, 1'b1, rbit());
        cyc(T_MEMWB, rbit(), rbit());
      end
      OP_SW: begin
        cyc(T_MEMADR, rbit(), rbit());
        repeat (mw) cyc(T_MEMWRITE, 1'b0, rbit());
        cyc(T_MEMWRITE, 1'b1, rbit());
      end
      OP_R:   begin cyc(T_EXECR, rbit(), rbit()); cyc(T_ALUWB, rbit(), rbit()); end
      OP_I:   begin cyc(T_EXECI, rbit(), rbit()); cyc(T_ALUWB, rbit(), rbit()); end
      OP_BEQ: cyc(T_BEQ, rbit(), z);
      OP_JAL: begin cyc(T_JAL, rbit(), rbit()); cyc(T_ALUWB, rbit(), rbit()); end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        repeat (10) cyc(T_HALT, rbit(), rbit());
`endif
      end
    endcase
  endtask

  // Reset asserted between edges; FETCH values must appear at once
  task automatic async_reset(input string tag);
    #2;
    bus.mem_ready = 1'b0;
    reset_n = 1'b0;
    exp_instret = 32'd0;
    #1;
    check(tag, observed(), {15'd0, 32'd0, exp_ctrl(T_FETCH, bus.op, bus.zero, 1'b0)});
    @(posedge clk);
    #1;
    check({tag, "_hold"}, observed(), {15'd0, 32'd0, exp_ctrl(T_FETCH, bus.op, bus.zero, 1'b0)});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.op = OP_LW;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("reset", observed(), {15'd0, 32'd0, exp_ctrl(T_FETCH, OP_LW, 1'b0, 1'b0)});
    @(negedge clk);
    reset_n = 1'b1;

    run_instr(OP_LW, 0, 0, 1'b0);
    run_instr(OP_SW, 1, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);
    run_instr(OP_R, 2, 0, 1'b0);
    run_instr(OP_I, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 2, 1'b0);
    run_instr(OP_BAD, 0, 0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    async_reset("halt_reset");
`endif
    run_instr(OP_SW, 0, 0, 1'b0);

    // lw interrupted by reset while waiting in MEMREAD
    bus.op = OP_LW;
    cyc(T_FETCH, 1'b1, 1'b0);
    cyc(T_DECODE, 1'b1, 1'b0);
    cyc(T_MEMADR, 1'b1, 1'b0);
    cyc(T_MEMREAD, 1'b0, 1'b0);
    async_reset("memread_reset");
    run_instr(OP_LW, 0, 1, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);

    if (sb_q.size() != 0) check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
